mux_pcp_gather: RTL and testbench

MUX_PCP_GATHER -- requirements
Module: mux_pcp_gather

---
 rtl/mux_pcp_gather_if.sv | 23 ++
 rtl/mux_pcp_gather.sv | 202 ++++++++++++++++++++
 tb/tb_mux_pcp_gather.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_pcp_gather_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_pcp_gather_if
// Brief    : AXI-Stream style bundle (valid/data/keep/last/ready) used for each
//            gather source and for the merged output of mux_pcp_gather.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_pcp_gather_if #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = DATA_W / 8
);
  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tready;

  // Producer side of a stream
  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  // Consumer side of a stream
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/mux_pcp_gather.sv
`default_nettype none
// ============================================================================
// Module   : mux_pcp_gather
// Brief    : 16:1 packet gather mux. Round-robin arbitration between packets,
//            the winner is locked until its tlast beat is accepted, beats are
//            forwarded through a single output register at up to 1 beat/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mux_pcp_gather #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic             clk,
  input  logic             rst,
  mux_pcp_gather_if.slave  s00_axis,
  mux_pcp_gather_if.slave  s01_axis,
  mux_pcp_gather_if.slave  s02_axis,
  mux_pcp_gather_if.slave  s03_axis,
  mux_pcp_gather_if.slave  s04_axis,
  mux_pcp_gather_if.slave  s05_axis,
  mux_pcp_gather_if.slave  s06_axis,
  mux_pcp_gather_if.slave  s07_axis,
  mux_pcp_gather_if.slave  s08_axis,
  mux_pcp_gather_if.slave  s09_axis,
  mux_pcp_gather_if.slave  s10_axis,
  mux_pcp_gather_if.slave  s11_axis,
  mux_pcp_gather_if.slave  s12_axis,
  mux_pcp_gather_if.slave  s13_axis,
  mux_pcp_gather_if.slave  s14_axis,
  mux_pcp_gather_if.slave  s15_axis,
  mux_pcp_gather_if.master m_axis,
  output logic [3:0]       grant_idx,
  output logic             busy,
  output logic [31:0]      pkt_count
);

  localparam int N_SRC = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [3:0]                   r_grant;
  logic [3:0]                   w_grant_nxt;
  logic [3:0]                   r_rr_ptr;
  logic [3:0]                   w_rr_ptr_nxt;

  logic [N_SRC-1:0]             w_s_valid;
  logic [N_SRC-1:0]             w_s_last;
  logic [N_SRC-1:0]             w_s_ready;
  logic [N_SRC-1:0][DATA_W-1:0] w_s_data;
  logic [N_SRC-1:0][KEEP_W-1:0] w_s_keep;

  logic                         w_found;
  logic [3:0]                   w_off;
  logic [3:0]                   w_pick;
  logic                         w_g_valid;
  logic                         w_g_last;
  logic [DATA_W-1:0]            w_g_data;
  logic [KEEP_W-1:0]            w_g_keep;
  logic                         w_out_ready;
  logic                         w_accept;

  logic                         r_m_valid;
  logic                         r_m_last;
  logic [DATA_W-1:0]            r_m_data;
  logic [KEEP_W-1:0]            r_m_keep;
  logic [31:0]                  r_pkt_count;

  // Flatten the sixteen source bundles into indexable vectors
  assign w_s_valid = {s15_axis.tvalid, s14_axis.tvalid, s13_axis.tvalid, s12_axis.tvalid,
                      s11_axis.tvalid, s10_axis.tvalid, s09_axis.tvalid, s08_axis.tvalid,
                      s07_axis.tvalid, s06_axis.tvalid, s05_axis.tvalid, s04_axis.tvalid,
                      s03_axis.tvalid, s02_axis.tvalid, s01_axis.tvalid, s00_axis.tvalid};
  assign w_s_last  = {s15_axis.tlast, s14_axis.tlast, s13_axis.tlast, s12_axis.tlast,
                      s11_axis.tlast, s10_axis.tlast, s09_axis.tlast, s08_axis.tlast,
                      s07_axis.tlast, s06_axis.tlast, s05_axis.tlast, s04_axis.tlast,
                      s03_axis.tlast, s02_axis.tlast, s01_axis.tlast, s00_axis.tlast};
  assign w_s_data  = {s15_axis.tdata, s14_axis.tdata, s13_axis.tdata, s12_axis.tdata,
                      s11_axis.tdata, s10_axis.tdata, s09_axis.tdata, s08_axis.tdata,
                      s07_axis.tdata, s06_axis.tdata, s05_axis.tdata, s04_axis.tdata,
                      s03_axis.tdata, s02_axis.tdata, s01_axis.tdata, s00_axis.tdata};
  assign w_s_keep  = {s15_axis.tkeep, s14_axis.tkeep, s13_axis.tkeep, s12_axis.tkeep,
                      s11_axis.tkeep, s10_axis.tkeep, s09_axis.tkeep, s08_axis.tkeep,
                      s07_axis.tkeep, s06_axis.tkeep, s05_axis.tkeep, s04_axis.tkeep,
                      s03_axis.tkeep, s02_axis.tkeep, s01_axis.tkeep, s00_axis.tkeep};

  assign s00_axis.tready = w_s_ready[0];
  assign s01_axis.tready = w_s_ready[1];
  assign s02_axis.tready = w_s_ready[2];
  assign s03_axis.tready = w_s_ready[3];
  assign s04_axis.tready = w_s_ready[4];
  assign s05_axis.tready = w_s_ready[5];
  assign s06_axis.tready = w_s_ready[6];
  assign s07_axis.tready = w_s_ready[7];
  assign s08_axis.tready = w_s_ready[8];
  assign s09_axis.tready = w_s_ready[9];
  assign s10_axis.tready = w_s_ready[10];
  assign s11_axis.tready = w_s_ready[11];
  assign s12_axis.tready = w_s_ready[12];
  assign s13_axis.tready = w_s_ready[13];
  assign s14_axis.tready = w_s_ready[14];
  assign s15_axis.tready = w_s_ready[15];

  // Round-robin search: offset of the first valid source at or above rr_ptr (4-bit index wraps 15->0)
  always_comb begin
    w_found = 1'b0;
    w_off   = 4'd0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!w_found && w_s_valid[r_rr_ptr + 4'(i)]) begin
        w_found = 1'b1;
        w_off   = 4'(i);
      end
    end
  end

  assign w_pick      = r_rr_ptr + w_off;
  assign w_g_valid   = w_s_valid[r_grant];
  assign w_g_last    = w_s_last[r_grant];
  assign w_g_data    = w_s_data[r_grant];
  assign w_g_keep    = w_s_keep[r_grant];
  // Output register can take a beat when empty or draining this cycle
  assign w_out_ready = !r_m_valid || m_axis.tready;

  // Next-state, grant/pointer update and source ready generation
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_s_ready    = '0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        w_s_ready[r_grant] = w_out_ready & ~rst;
        w_accept           = w_g_valid & w_out_ready;
        if (w_accept && w_g_last) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = r_grant + 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= 4'd0;
      r_rr_ptr <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Output register: load on accept, clear valid on drain, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_last  <= w_g_last;
      r_m_data  <= w_g_data;
      r_m_keep  <= w_g_keep;
    end else if (r_m_valid && m_axis.tready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Completed-packet counter, counts tlast handshakes on the output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_count <= 32'd0;
    end else if (r_m_valid && m_axis.tready && r_m_last) begin
      r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tdata  = r_m_data;
  assign m_axis.tkeep  = r_m_keep;
  assign m_axis.tlast  = r_m_last;
  assign grant_idx     = r_grant;
  assign busy          = (r_state == ST_LOCKED);
  assign pkt_count     = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_mux_pcp_gather.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_pcp_gather
// Brief    : Self-checking bench for mux_pcp_gather: vector table, directed
//            corner sequences and randomized traffic against a packet model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_pcp_gather;

  localparam int DATA_W = 128;
  localparam int KEEP_W = DATA_W / 8;
  localparam int N_SRC  = 16;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  typedef struct {
    int          src;
    int          len;
    logic [31:0] base;
    int          exp_grant;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_SRC-1:0]  s_valid;
  logic [N_SRC-1:0]  s_last;
  logic [N_SRC-1:0]  s_ready;
  logic [DATA_W-1:0] s_data [N_SRC];
  logic [KEEP_W-1:0] s_keep [N_SRC];
  logic              m_ready;
  logic [3:0]        grant_idx;
  logic              busy;
  logic [31:0]       pkt_count;

  mux_pcp_gather_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) s_if [N_SRC] ();
  mux_pcp_gather_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) m_if ();

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign s_if[g].tvalid = s_valid[g];
    assign s_if[g].tdata  = s_data[g];
    assign s_if[g].tkeep  = s_keep[g];
    assign s_if[g].tlast  = s_last[g];
    assign s_ready[g]     = s_if[g].tready;
  end
  assign m_if.tready = m_ready;

  mux_pcp_gather #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .s00_axis (s_if[0]),
    .s01_axis (s_if[1]),
    .s02_axis (s_if[2]),
    .s03_axis (s_if[3]),
    .s04_axis (s_if[4]),
    .s05_axis (s_if[5]),
    .s06_axis (s_if[6]),
    .s07_axis (s_if[7]),
    .s08_axis (s_if[8]),
    .s09_axis (s_if[9]),
    .s10_axis (s_if[10]),
    .s11_axis (s_if[11]),
    .s12_axis (s_if[12]),
    .s13_axis (s_if[13]),
    .s14_axis (s_if[14]),
    .s15_axis (s_if[15]),
    .m_axis   (m_if),
    .grant_idx(grant_idx),
    .busy     (busy),
    .pkt_count(pkt_count)
  );

  beat_t       srcq [N_SRC][$];   // beats still to be offered by each source
  beat_t       mq   [N_SRC][$];   // model copy of the offered packets
  beat_t       exp_q[$];          // expected merged output stream
  int          gapc [N_SRC];
  int          acc_first [N_SRC];
  int          acc_last  [N_SRC];
  int          out_cyc[$];
  int          grant_log[$];
  int          gap_mode = 0;      // 0 none, 1 random, 2 fixed 3-cycle gaps mid-packet
  int          rdy_mode = 0;      // 0 always, 1 toggle 1010, 2 random, 3 never
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          m_ptr = 0;
  logic [31:0] exp_pkts = 32'd0;

  logic              prev_stall = 1'b0;
  logic              prev_rst   = 1'b1;
  logic              prev_busy  = 1'b0;
  logic [DATA_W-1:0] prev_md;
  logic [KEEP_W-1:0] prev_mk;
  logic              prev_ml;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_pkt(input int src, input int len, input bit seq, input logic [31:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      if (seq) begin
        b.data = DATA_W'(base) + DATA_W'(k);
        b.keep = '1;
      end else begin
        b.data = {$urandom(), $urandom(), $urandom(), $urandom()};
        b.data[DATA_W-1 -: 8] = 8'(src);
        b.keep = KEEP_W'($urandom());
      end
      b.last = (k == len - 1);
      srcq[src].push_back(b);
      mq[src].push_back(b);
    end
  endtask

  // Packet-level model: whole packets leave in round-robin order from the pointer
  task automatic resolve();
    beat_t b;
    int    s;
    forever begin
      s = -1;
      for (int i = 0; i < N_SRC; i++) begin
        if (s < 0 && mq[(m_ptr + i) % N_SRC].size() > 0) s = (m_ptr + i) % N_SRC;
      end
      if (s < 0) break;
      do begin
        b = mq[s].pop_front();
        exp_q.push_back(b);
      end while (!b.last);
      exp_pkts = exp_pkts + 32'd1;
      m_ptr = (s + 1) % N_SRC;
    end
  endtask

  function automatic bit src_pending();
    for (int i = 0; i < N_SRC; i++) if (srcq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic sample();
    beat_t b;
    if (rst) chk("tready_in_reset", s_ready, '0);
    chk("tready_onehot0", $onehot0(s_ready), 1);
    if (m_if.tvalid && !m_ready) chk("tready_while_full", s_ready, '0);
    if (prev_stall && !prev_rst && !rst) begin
      chk("hold_tdata", m_if.tdata, prev_md);
      chk("hold_ctrl", {m_if.tvalid, m_if.tkeep, m_if.tlast}, {1'b1, prev_mk, prev_ml});
    end
    if (!rst && m_if.tvalid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", m_if.tdata, '0);
      end else begin
        b = exp_q.pop_front();
        chk("out_tdata", m_if.tdata, b.data);
        chk("out_tkeep_tlast", {m_if.tkeep, m_if.tlast}, {b.keep, b.last});
      end
      out_cyc.push_back(cyc);
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (s_valid[i] && s_ready[i] && srcq[i].size() > 0) begin
        b = srcq[i].pop_front();
        if (acc_first[i] < 0) acc_first[i] = cyc;
        acc_last[i] = cyc;
        if (!b.last) gapc[i] = (gap_mode == 2) ? 3 : (gap_mode == 1) ? int'($urandom % 3) : 0;
      end
    end
    if (!rst && busy && !prev_busy) grant_log.push_back(int'(grant_idx));
    prev_stall = m_if.tvalid && !m_ready;
    prev_md    = m_if.tdata;
    prev_mk    = m_if.tkeep;
    prev_ml    = m_if.tlast;
    prev_rst   = rst;
    prev_busy  = busy;
  endtask

  // One clock: drive at the falling edge, sample just after, then step the rising edge
  task automatic cycle();
    for (int i = 0; i < N_SRC; i++) begin
      if (srcq[i].size() == 0 || gapc[i] > 0) begin
        if (gapc[i] > 0) gapc[i]--;
        s_valid[i] = 1'b0;
        s_data[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_keep[i]  = KEEP_W'($urandom());
        s_last[i]  = 1'($urandom());
      end else begin
        s_valid[i] = 1'b1;
        s_data[i]  = srcq[i][0].data;
        s_keep[i]  = srcq[i][0].keep;
        s_last[i]  = srcq[i][0].last;
      end
    end
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 2 == 0);
      2:       m_ready = 1'($urandom);
      default: m_ready = 1'b0;
    endcase
    #1;
    sample();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      srcq[i].delete();
      mq[i].delete();
      gapc[i] = 0;
      acc_first[i] = -1;
      acc_last[i]  = -1;
    end
    exp_q.delete();
    m_ptr    = 0;
    exp_pkts = 32'd0;
  endtask

  task automatic run_until_done(input string name, input int max_cyc);
    int n = 0;
    while ((exp_q.size() > 0 || src_pending()) && n < max_cyc) begin
      cycle();
      n++;
    end
    if (n >= max_cyc) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d beats outstanding after %0d cycles, required 0", name, exp_q.size(), n);
      do_reset();
    end
    repeat (2) cycle();
    chk({name, "_pkt_count"}, pkt_count, exp_pkts);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  vec_t vecs [4];
  int   rr_exp [9];
  int   t0;

  initial begin
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      s_data[i] = '0;
      s_keep[i] = '0;
    end
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_m_tkeep_tlast", {m_if.tkeep, m_if.tlast}, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_count", pkt_count, 0);

    // Single-packet vectors from idle with an always-ready sink
    vecs[0] = '{src: 3,  len: 4, base: 32'h1,  exp_grant: 3,  exp_lat: 2};
    vecs[1] = '{src: 0,  len: 1, base: 32'h10, exp_grant: 0,  exp_lat: 2};
    vecs[2] = '{src: 15, len: 3, base: 32'h20, exp_grant: 15, exp_lat: 2};
    vecs[3] = '{src: 8,  len: 5, base: 32'h30, exp_grant: 8,  exp_lat: 2};
    gap_mode = 0;
    rdy_mode = 0;
    for (int v = 0; v < 4; v++) begin
      out_cyc.delete();
      grant_log.delete();
      add_pkt(vecs[v].src, vecs[v].len, 1'b1, vecs[v].base);
      resolve();
      t0 = cyc;
      run_until_done("vec", 60);
      chk("vec_beats_out", out_cyc.size(), vecs[v].len);
      for (int k = 0; k < vecs[v].len && k < out_cyc.size(); k++)
        chk("vec_beat_cycle", out_cyc[k] - t0, vecs[v].exp_lat + k);
      chk("vec_grant", (grant_log.size() > 0) ? grant_log[0] : -1, vecs[v].exp_grant);
      chk("vec_grant_hold", grant_idx, vecs[v].exp_grant);
    end

    // Reset during beat 2 of a 4-beat packet, then arbitration restarts at source 0
    rdy_mode = 3;
    add_pkt(9, 4, 1'b1, 32'h40);
    repeat (3) cycle();
    do_reset();
    chk("midrst_m_tvalid", m_if.tvalid, 0);
    chk("midrst_pkt_count", pkt_count, 0);
    chk("midrst_busy", busy, 0);
    rdy_mode = 0;
    grant_log.delete();
    add_pkt(12, 1, 1'b0, 32'h0);
    add_pkt(4, 1, 1'b0, 32'h0);
    resolve();
    run_until_done("midrst", 60);
    chk("midrst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 4);

    // Round robin among continuously-valid sources 0, 5 and 15
    do_reset();
    rr_exp = '{0, 5, 15, 0, 5, 15, 0, 5, 15};
    grant_log.delete();
    for (int r = 0; r < 3; r++) begin
      add_pkt(0, 1, 1'b0, 32'h0);
      add_pkt(5, 1, 1'b0, 32'h0);
      add_pkt(15, 1, 1'b0, 32'h0);
    end
    resolve();
    run_until_done("rr", 100);
    chk("rr_grants", grant_log.size(), 9);
    for (int k = 0; k < 9 && k < grant_log.size(); k++) chk("rr_order", grant_log[k], rr_exp[k]);

    // Lock: source 2 stalls mid-packet while source 7 waits
    do_reset();
    gap_mode = 2;
    grant_log.delete();
    add_pkt(2, 4, 1'b0, 32'h0);
    add_pkt(7, 2, 1'b0, 32'h0);
    resolve();
    run_until_done("lock", 100);
    chk("lock_s7_after_s2_last", acc_first[7] > acc_last[2], 1);
    chk("lock_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 2);

    // Backpressure: sink ready toggles during a 6-beat packet
    gap_mode = 0;
    rdy_mode = 1;
    out_cyc.delete();
    add_pkt(11, 6, 1'b0, 32'h0);
    resolve();
    run_until_done("bp", 100);
    chk("bp_beats_out", out_cyc.size(), 6);

    // Packet counter wrap
    rdy_mode = 0;
    force dut.r_pkt_count = 32'hFFFF_FFFF;
    cycle();
    release dut.r_pkt_count;
    exp_pkts = 32'hFFFF_FFFF;
    cycle();
    chk("wrap_preset", pkt_count, 32'hFFFF_FFFF);
    add_pkt(6, 2, 1'b0, 32'h0);
    resolve();
    run_until_done("wrap", 60);
    chk("wrap_zero", pkt_count, 0);

    // Randomized multi-source traffic with source gaps and random sink stalls
    gap_mode = 1;
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      int np = $urandom_range(3, 10);
      for (int p = 0; p < np; p++) add_pkt($urandom % N_SRC, $urandom_range(1, 5), 1'b0, 32'h0);
      resolve();
      run_until_done("rand", 3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
